// File: rtl/axis_chk_pkg.sv
// Shared definitions for the AXI-Stream frame checker.
//   chk_state_t : checker FSM states
//   LFSR_SEED   : backpressure LFSR reload value
//   LFSR_TAPS   : feedback mask for the right-shifting Fibonacci LFSR.
//                 Bits 0,2,3,5 correspond to x^16+x^14+x^13+x^11+1.
//   clog2_min1  : index/count width helper that never returns 0
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_chk_lfsr.sv
// 16-bit Fibonacci LFSR driving the pseudo-random TREADY pattern.
//   clk, rst : clock, async active-high reset (reloads the seed)
//   load     : reload the seed (takes priority over en)
//   en       : advance one step
//   rnd_nxt  : bit 0 of the value the register holds after this edge, so the
//              parent can register TREADY in step with the LFSR itself
module axis_chk_lfsr
  import axis_chk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic rnd_nxt
);

  logic [15:0] q;
  logic [15:0] nxt;

  always_comb begin
    nxt = q;
    if (load)    nxt = LFSR_SEED;
    else if (en) nxt = {^(q & LFSR_TAPS), q[15:1]};
  end

  assign rnd_nxt = nxt[0];

  always_ff @(posedge clk or posedge rst)
    if (rst) q <= LFSR_SEED;
    else     q <= nxt;

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream frame checker: compares one incoming frame of NUM_BEATS beats
// against an on-chip expected-word table and reports per-frame results.
//   aclk, areset             : clock, async active-high reset
//   exp_we/exp_addr/exp_data : expected-table write port (ignored while RUN)
//   start                    : arm for one frame (from IDLE or DONE)
//   bp_en                    : pseudo-random TREADY backpressure
//   S_AXIS_*                 : stream slave; TREADY is registered
//   busy                     : frame in progress
//   done                     : one-cycle pulse when the frame ends
//   pass/err_count/first_err_idx/err_last/timeout : results, held until start
module axis_frame_checker
  import axis_chk_pkg::*;
#(
  parameter  int TBITS     = 64,
  parameter  int TBYTE     = TBITS / 8,
  parameter  int NUM_BEATS = 8,
  parameter  int TIMEOUT   = 1024,
  localparam int IDXW      = clog2_min1(NUM_BEATS),
  localparam int CNTW      = clog2_min1(NUM_BEATS + 1)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             exp_we,
  input  logic [IDXW-1:0]  exp_addr,
  input  logic [TBITS-1:0] exp_data,
  input  logic             start,
  input  logic             bp_en,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [TBITS-1:0] S_AXIS_TDATA,
  input  logic [TBYTE-1:0] S_AXIS_TKEEP,
  input  logic             S_AXIS_TLAST,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNTW-1:0]  err_count,
  output logic [IDXW-1:0]  first_err_idx,
  output logic             err_last,
  output logic             timeout
);

  localparam int TOW = clog2_min1(TIMEOUT + 1);

  chk_state_t       state;
  logic [IDXW-1:0]  beat_idx;
  logic [TOW-1:0]   idle_cnt;
  logic [TBITS-1:0] exp_mem [NUM_BEATS];
  logic [TBITS-1:0] exp_word;
  logic [TBYTE-1:0] byte_mis;

  logic run, arm, acc, mism, is_last, lerr, fin_beat, to_hit, frame_end;
  logic addr_ok, rnd_nxt, tready_nxt;
  logic [CNTW-1:0] err_count_nxt;
  logic            err_last_nxt, timeout_nxt;

  assign run = (state == RUN);
  assign arm = start & ~run;

  // Expected-word table: no reset, writes blocked while a frame is running.
  if ((1 << IDXW) > NUM_BEATS) begin : g_addr_chk
    assign addr_ok = (exp_addr < IDXW'(NUM_BEATS));
  end else begin : g_addr_full
    assign addr_ok = 1'b1;
  end

  always_ff @(posedge aclk)
    if (exp_we && !run && addr_ok) exp_mem[exp_addr] <= exp_data;

  assign exp_word = exp_mem[beat_idx];

  // Per-byte compare; bytes with TKEEP low never count as a mismatch.
  for (genvar b = 0; b < TBYTE; b++) begin : g_byte
    assign byte_mis[b] = S_AXIS_TKEEP[b] & (S_AXIS_TDATA[8*b +: 8] != exp_word[8*b +: 8]);
  end

  axis_chk_lfsr u_lfsr (
    .clk     (aclk),
    .rst     (areset),
    .load    (arm),
    .en      (run),
    .rnd_nxt (rnd_nxt)
  );

  assign tready_nxt = ~bp_en | rnd_nxt;

  always_comb begin
    acc      = run & S_AXIS_TVALID & S_AXIS_TREADY;
    mism     = acc & (|byte_mis);
    is_last  = (beat_idx == IDXW'(NUM_BEATS - 1));
    // TLAST must appear exactly on the final beat: early or missing both flag.
    lerr     = acc & (S_AXIS_TLAST ^ is_last);
    fin_beat = acc & (S_AXIS_TLAST | is_last);
    // Only idle cycles can expire the watchdog, so an acceptance on the
    // would-be timeout cycle wins automatically.
    to_hit   = (TIMEOUT != 0) && run && !acc && (idle_cnt == TOW'(TIMEOUT - 1));
    frame_end = fin_beat | to_hit;

    err_count_nxt = err_count;
    if (mism && err_count != CNTW'(NUM_BEATS)) err_count_nxt = err_count + 1'b1;
    err_last_nxt = err_last | lerr;
    timeout_nxt  = timeout | to_hit;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      beat_idx      <= '0;
      idle_cnt      <= '0;
      S_AXIS_TREADY <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      err_last      <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            beat_idx      <= '0;
            idle_cnt      <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            err_last      <= 1'b0;
            timeout       <= 1'b0;
            pass          <= 1'b0;
            S_AXIS_TREADY <= tready_nxt;
          end
        end
        RUN: begin
          err_count <= err_count_nxt;
          err_last  <= err_last_nxt;
          timeout   <= timeout_nxt;
          if (mism && err_count == '0) first_err_idx <= beat_idx;
          if (acc) idle_cnt <= '0;
          else     idle_cnt <= idle_cnt + 1'b1;
          if (acc && !is_last) beat_idx <= beat_idx + 1'b1;
          if (frame_end) begin
            state         <= DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
            S_AXIS_TREADY <= 1'b0;
            pass          <= (err_count_nxt == '0) & ~err_last_nxt & ~timeout_nxt;
          end else begin
            S_AXIS_TREADY <= tready_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Randomized self-checking bench for axis_frame_checker. A frame-level model
// walks the accepted beats and applies the frame rules (byte-masked compare,
// TLAST placement, watchdog on consecutive idle cycles) to predict results.
module tb_axis_frame_checker;

  localparam int NB = 8;
  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_addr = '0;
  logic [63:0] exp_data = '0;
  logic        start = 1'b0;
  logic        bp_en = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        busy, done, pass, err_last, timeout;
  logic [3:0]  err_count;
  logic [2:0]  first_err_idx;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] exp_ref [NB];
  logic [63:0] pd [NB];
  logic [7:0]  pk [NB];
  bit          pl [NB];

  axis_frame_checker #(.TBITS(64), .NUM_BEATS(NB), .TIMEOUT(TO)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .exp_we        (exp_we),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .start         (start),
    .bp_en         (bp_en),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TKEEP  (tkeep),
    .S_AXIS_TLAST  (tlast),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .err_last      (err_last),
    .timeout       (timeout)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tready"}, tready, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".errcnt"}, err_count, 0);
    chk({tag, ".first"}, first_err_idx, 0);
    chk({tag, ".errlast"}, err_last, 0);
    chk({tag, ".timeout"}, timeout, 0);
  endtask

  task automatic load_exp(input int k, input logic [63:0] d);
    @(posedge aclk); #1;
    exp_we = 1'b1; exp_addr = 3'(k); exp_data = d;
    @(posedge aclk); #1;
    exp_we = 1'b0;
    exp_ref[k] = d;
  endtask

  task automatic set_clean();
    for (int k = 0; k < NB; k++) begin
      pd[k] = exp_ref[k];
      pk[k] = 8'hFF;
      pl[k] = (k == NB - 1);
    end
  endtask

  // Arms the checker and streams pd/pk/pl. stall_after>=0 stops TVALID after
  // that beat; abort_after>=0 applies reset once that beat is accepted;
  // wr_noise drives table writes throughout the frame (they must be dropped).
  task automatic run_frame(input string tag, input bit bp, input int vld_pct,
                           input int stall_after, input int abort_after,
                           input bit wr_noise, output int ncyc, output int nlows);
    int k, idle, cyc, lows, m_err, m_first;
    bit m_last, m_to, ended, acc, mis;
    k = 0; idle = 0; cyc = 0; lows = 0; m_err = 0; m_first = 0;
    m_last = 0; m_to = 0; ended = 0;
    ncyc = 0; nlows = 0;
    start = 1'b1; bp_en = bp;
    @(posedge aclk); #1;
    start = 1'b0;
    while (!ended && cyc < 400) begin
      tvalid = (stall_after < 0 || k <= stall_after) && ($urandom_range(0, 99) < vld_pct);
      tdata = pd[k]; tkeep = pk[k]; tlast = pl[k];
      if (wr_noise) begin
        exp_we = 1'b1; exp_addr = 3'($urandom_range(0, NB - 1)); exp_data = {$urandom, $urandom};
      end
      chk({tag, ".busy"}, busy, 1);
      if (!tready) lows++;
      acc = tvalid & tready;
      @(posedge aclk); #1;
      exp_we = 1'b0;
      cyc++;
      if (acc) begin
        mis = 0;
        for (int b = 0; b < 8; b++)
          if (pk[k][b] && pd[k][8*b +: 8] != exp_ref[k][8*b +: 8]) mis = 1;
        if (mis) begin
          if (m_err == 0) m_first = k;
          if (m_err < NB) m_err++;
        end
        if (pl[k] != (k == NB - 1)) m_last = 1;
        if (pl[k] || k == NB - 1) ended = 1;
        k++;
        idle = 0;
        if (abort_after >= 0 && k > abort_after) begin
          areset = 1'b1;
          #1;
          chk_zero({tag, ".rst"});
          tvalid = 1'b0;
          @(posedge aclk); @(posedge aclk); #1;
          chk_zero({tag, ".rsthold"});
          areset = 1'b0;
          return;
        end
      end else begin
        idle++;
        if (idle == TO) begin m_to = 1; ended = 1; end
      end
      if (!ended) chk({tag, ".nodone"}, done, 0);
    end
    tvalid = 1'b0; tlast = 1'b0;
    if (!ended) chk({tag, ".bound"}, 0, 1);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_lo"}, busy, 0);
    chk({tag, ".tready_lo"}, tready, 0);
    chk({tag, ".errcnt"}, err_count, m_err);
    chk({tag, ".first"}, first_err_idx, m_first);
    chk({tag, ".errlast"}, err_last, m_last);
    chk({tag, ".timeout"}, timeout, m_to);
    chk({tag, ".pass"}, pass, (m_err == 0) && !m_last && !m_to);
    if (!bp) chk({tag, ".nobp"}, lows, 0);
    ncyc = cyc; nlows = lows;
    @(posedge aclk); #1;
    chk({tag, ".pulse"}, done, 0);
    chk({tag, ".hold"}, pass, (m_err == 0) && !m_last && !m_to);
  endtask

  initial begin
    int ncyc, nlows;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    for (int k = 0; k < NB; k++) load_exp(k, 64'h0101_0101_0101_0101 * 64'(k + 1));

    set_clean();
    run_frame("clean", 0, 100, -1, -1, 0, ncyc, nlows);
    chk("clean.lat", ncyc, NB);

    set_clean(); pd[3] ^= 64'h1; pk[3] = 8'hFE;
    run_frame("masked", 0, 100, -1, -1, 0, ncyc, nlows);
    pk[3] = 8'hFF;
    run_frame("unmasked", 0, 100, -1, -1, 0, ncyc, nlows);

    set_clean(); pd[2] ^= 64'hFF00; pd[5] ^= (64'h1 << 60);
    run_frame("multi", 0, 100, -1, -1, 0, ncyc, nlows);

    set_clean(); pl[5] = 1;
    run_frame("early_last", 0, 100, -1, -1, 0, ncyc, nlows);
    chk("early_last.lat", ncyc, 6);

    set_clean(); pl[NB - 1] = 0;
    run_frame("no_last", 0, 100, -1, -1, 0, ncyc, nlows);

    set_clean();
    run_frame("bp", 1, 100, -1, -1, 0, ncyc, nlows);
    chk("bp.toggle", nlows != 0, 1);

    set_clean();
    run_frame("tmo", 0, 100, 4, -1, 0, ncyc, nlows);
    chk("tmo.lat", ncyc, 5 + TO);

    set_clean();
    run_frame("wrnoise", 0, 100, -1, -1, 1, ncyc, nlows);

    set_clean();
    run_frame("abort", 0, 100, -1, 4, 0, ncyc, nlows);
    run_frame("rearm", 0, 100, -1, -1, 0, ncyc, nlows);

    for (int k = 0; k < NB; k++) load_exp(k, {$urandom, $urandom});
    for (int f = 0; f < 40; f++) begin
      set_clean();
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, 3) == 0) pd[k] ^= (64'h1 << $urandom_range(0, 63));
        if ($urandom_range(0, 1) == 0) pk[k] = 8'($urandom);
      end
      if ($urandom_range(0, 5) == 0) pl[$urandom_range(0, NB - 2)] = 1;
      if ($urandom_range(0, 5) == 0) pl[NB - 1] = 0;
      run_frame("rand", 1'($urandom_range(0, 1)), $urandom_range(40, 100), -1, -1,
                1'($urandom_range(0, 1)), ncyc, nlows);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_frame_checker.md
# axis_frame_checker

Synthesizable, parametrised AXI-Stream frame checker for the QR-CORDIC datapath: holds an expected frame of `NUM_BEATS` words, accepts one frame from a stream master (e.g. the `M_AXIS_S2MM_*` output of `yolo_top`) and reports per-frame pass/fail.
- Generalises the fixed 64-bit / 8-column compare loop into on-chip hardware.
- Adds byte-masked compare, TLAST checking, pseudo-random backpressure, a timeout watchdog and error statistics.
- Intended for on-board self-test and for simulation benches.

## Interface
Parameters:
- `TBITS`, 64, stream data width (multiple of 8)
- `TBYTE`, `TBITS/8`, keep width
- `NUM_BEATS`, 8, beats per frame (≥2)
- `TIMEOUT`, 1024, idle cycles in RUN before timeout; 0 disables
- Derived: `IDXW = max(1, $clog2(NUM_BEATS))`, `CNTW = $clog2(NUM_BEATS+1)`

Ports:
- `aclk`  in  1  clock
- `areset`  in  1  asynchronous, active-high reset
- `exp_we`  in  1  expected-word write strobe
- `exp_addr`  in  IDXW  expected-word index
- `exp_data`  in  TBITS  expected word
- `start`  in  1  arm checker for one frame
- `bp_en`  in  1  enable pseudo-random TREADY backpressure
- `S_AXIS_TVALID`  in  1  stream valid
- `S_AXIS_TREADY`  out  1  stream ready (registered)
- `S_AXIS_TDATA`  in  TBITS  stream data
- `S_AXIS_TKEEP`  in  TBYTE  byte-valid mask
- `S_AXIS_TLAST`  in  1  end of frame
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at frame end
- `pass`  out  1  frame result, held until next `start`
- `err_count`  out  CNTW  mismatching beats in the frame
- `first_err_idx`  out  IDXW  index of the first mismatching beat
- `err_last`  out  1  TLAST protocol error
- `timeout`  out  1  watchdog expired

## Operation
- Expected-word memory: `NUM_BEATS × TBITS` register array, not reset.
  - Written when `exp_we` and state≠RUN.
  - Writes with `exp_addr ≥ NUM_BEATS` or during RUN are dropped.
- States:
  - IDLE → RUN on `start`; clears beat index, `err_count`, `first_err_idx`, `err_last`, `timeout`, `pass` and the idle counter.
  - RUN → DONE on: final beat accepted, early TLAST, or timeout.
  - DONE → RUN on `start`; otherwise DONE is held.
  - `start` in RUN is ignored.
- Beat accepted when `S_AXIS_TVALID & S_AXIS_TREADY`.
  - Accepted beat at index k compares against `exp[k]`.
  - Mismatch when any byte b has `TKEEP[b]=1` and data≠expected; bytes with `TKEEP[b]=0` are ignored.
- Errors:
  - On the first mismatch, `first_err_idx` = k. `err_count` increments per mismatching beat and saturates at `NUM_BEATS`.
  - TLAST on k < `NUM_BEATS-1`: `err_last`=1 and the frame ends.
  - TLAST absent on k = `NUM_BEATS-1`: `err_last`=1 and the frame ends.
- Result: `pass = (err_count==0) & !err_last & !timeout`, valid from the `done` cycle onward.
- Watchdog: the idle counter increments each RUN cycle with no accepted beat and clears on acceptance. When it reaches `TIMEOUT` (nonzero), `timeout`=1 and the frame ends.
- Backpressure: a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1, reloaded by reset and by `start`. It advances every RUN cycle.
  - TREADY next = RUN & (!`bp_en` | lfsr[0]).

## Timing
- Reset values (all outputs and state): `S_AXIS_TREADY`, `busy`, `done`, `pass`, `err_count`, `first_err_idx`, `err_last`, `timeout` = 0; state IDLE.
- Reset mid-frame aborts immediately. No `done` pulse; the LFSR is reseeded.
- TREADY rises the cycle after `start` is sampled and falls in the cycle `done` is asserted.
- Last beat accepted in cycle N: `done`=1 and final stats visible in cycle N+1; `busy`=0 in N+1.
- With `bp_en`=0 and TVALID held high, an `NUM_BEATS`-beat frame completes in `NUM_BEATS` accepting cycles, with `done` at `start`+`NUM_BEATS`+1.
- Simultaneous timeout and acceptance in the same cycle: acceptance wins and the counter clears.
- Simultaneous early TLAST and data mismatch on the same beat: both are recorded.

## Structure
- Package `axis_chk_pkg`:
  - state enum {IDLE, RUN, DONE}
  - `LFSR_SEED`, `LFSR_TAPS`
  - width helper function for `IDXW`/`CNTW`
- Sub-module `axis_chk_lfsr` (16-bit, with load and enable inputs), instantiated once.
- The remaining logic (memory, FSM, compare, counters) lives in the top module.

## Test plan
- Clean frame: load exp[k]=64'h0101_0101_0101_0101×(k+1), `bp_en`=0, stream the identical frame with TLAST on beat 7 → `done` at `start`+9, `pass`=1, `err_count`=0.
- Masked mismatch: beat 3 byte 0 differs, TKEEP=8'hFE → `pass`=1. Repeat with TKEEP=8'hFF → `err_count`=1, `first_err_idx`=3, `pass`=0.
- Multiple errors: beats 2 and 5 corrupted → `err_count`=2, `first_err_idx`=2.
- TLAST errors:
  - TLAST on beat 5 → `done` the cycle after beat 5, `err_last`=1.
  - No TLAST on beat 7 → `err_last`=1.
- Backpressure and timeout: `bp_en`=1 gives identical results to the clean frame with TREADY toggling. With `TIMEOUT`=16 and the source stalled after beat 4 → `timeout`=1, `pass`=0, `done` 16 cycles after beat 4.
- Reset mid-frame at beat 4, then a re-armed clean frame → all outputs 0 during reset, then `pass`=1.
